// File: rtl/calc_sequencer.sv
// calc_sequencer: operand/operation entry sequencer that drives a registered 4-bit ALU and shows its result.
// Latency: outputs are registered and follow the state they belong to; the ALU answers one cycle after op_code=101.
// Backpressure: none; next/clear are single-cycle pulses, and next is dropped in ISSUE, WAIT_DONE and ERROR.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   sw, next, clear      operand/op switches, advance pulse, return-to-ENTER_A pulse
//   alu_a, alu_b         registered operands to the ALU
//   op_code, compute_op  registered ALU instruction and arithmetic operation
//   alu_result, alu_done, alu_div_by_zero, alu_negative   ALU responses
//   disp_value           registered display value
//   state_out            current state encoding
//   busy, err, neg       operation in flight, fault latched, last SUB result negative
// Optional build macro CALC_SEQ_CHAIN_EN: next in SHOW feeds result[3:0] back as operand A
// and resumes at ENTER_B instead of ENTER_A.

module calc_sequencer #(
   parameter int TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] sw,
   input  logic       next,
   input  logic       clear,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] op_code,
   output logic [1:0] compute_op,
   input  logic [7:0] alu_result,
   input  logic       alu_done,
   input  logic       alu_div_by_zero,
   input  logic       alu_negative,
   output logic [7:0] disp_value,
   output logic [2:0] state_out,
   output logic       busy,
   output logic       err,
   output logic       neg
);

   typedef enum logic [2:0] {
      ENTER_A   = 3'd0,
      ENTER_B   = 3'd1,
      ENTER_OP  = 3'd2,
      ISSUE     = 3'd3,
      WAIT_DONE = 3'd4,
      SHOW      = 3'd5,
      ERROR     = 3'd6
   } state_t;

   localparam logic [2:0] OP_NOOP   = 3'b000;
   localparam logic [2:0] OP_DISP_A = 3'b010;
   localparam logic [2:0] OP_DISP_B = 3'b100;
   localparam logic [2:0] OP_COMP   = 3'b101;
   localparam logic [2:0] OP_DISP_R = 3'b110;
   localparam logic [7:0] LAST_CNT  = 8'(TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [7:0] result, result_nxt;
   logic [7:0] count, count_nxt;
   logic [3:0] alu_a_nxt, alu_b_nxt;
   logic [1:0] compute_op_nxt;
   logic [2:0] op_code_nxt;
   logic [7:0] disp_nxt;
   logic       busy_nxt, err_nxt, neg_nxt;

   assign state_out = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ENTER_A;
         alu_a      <= 4'h0;
         alu_b      <= 4'h0;
         compute_op <= 2'b00;
         op_code    <= OP_DISP_A;
         result     <= 8'h00;
         disp_value <= 8'h00;
         count      <= 8'h00;
         busy       <= 1'b0;
         err        <= 1'b0;
         neg        <= 1'b0;
      end else begin
         state      <= state_nxt;
         alu_a      <= alu_a_nxt;
         alu_b      <= alu_b_nxt;
         compute_op <= compute_op_nxt;
         op_code    <= op_code_nxt;
         result     <= result_nxt;
         disp_value <= disp_nxt;
         count      <= count_nxt;
         busy       <= busy_nxt;
         err        <= err_nxt;
         neg        <= neg_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      alu_a_nxt      = alu_a;
      alu_b_nxt      = alu_b;
      compute_op_nxt = compute_op;
      result_nxt     = result;
      count_nxt      = count;
      neg_nxt        = neg;

      if (clear) begin
         // Operands, operation and result are deliberately kept across a clear.
         state_nxt = ENTER_A;
         neg_nxt   = 1'b0;
      end else begin
         case (state)
            ENTER_A: begin
               if (next) begin
                  alu_a_nxt = sw;
                  state_nxt = ENTER_B;
               end
            end
            ENTER_B: begin
               if (next) begin
                  alu_b_nxt = sw;
                  state_nxt = ENTER_OP;
               end
            end
            ENTER_OP: begin
               if (next) begin
                  compute_op_nxt = sw[1:0];
                  state_nxt      = ISSUE;
               end
            end
            ISSUE: begin
               count_nxt = 8'h00;
               state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
               count_nxt = count + 8'd1;
               // Divide-by-zero wins over done; timeout only when the ALU is silent.
               if (alu_div_by_zero) begin
                  state_nxt = ERROR;
               end else if (alu_done) begin
                  result_nxt = alu_result;
                  neg_nxt    = (compute_op == 2'b01) && alu_negative;
                  state_nxt  = SHOW;
               end else if (count == LAST_CNT) begin
                  state_nxt = ERROR;
               end
            end
            SHOW: begin
               if (next) begin
`ifdef CALC_SEQ_CHAIN_EN
                  alu_a_nxt = result[3:0];
                  state_nxt = ENTER_B;
`else
                  state_nxt = ENTER_A;
`endif
               end
            end
            ERROR: begin
               state_nxt = ERROR;
            end
            default: begin
               state_nxt = ENTER_A;
            end
         endcase
      end
   end

   // Registered outputs are decoded from the next state so they line up
   // with the state register rather than lagging it by a cycle.
   always_comb begin
      op_code_nxt = OP_NOOP;
      disp_nxt    = disp_value;
      busy_nxt    = 1'b0;
      err_nxt     = 1'b0;
      case (state_nxt)
         ENTER_A: begin
            op_code_nxt = OP_DISP_A;
            disp_nxt    = {4'h0, sw};
         end
         ENTER_B: begin
            op_code_nxt = OP_DISP_B;
            disp_nxt    = {4'h0, sw};
         end
         ENTER_OP: begin
            disp_nxt = {6'h00, sw[1:0]};
         end
         ISSUE: begin
            op_code_nxt = OP_COMP;
            busy_nxt    = 1'b1;
         end
         WAIT_DONE: begin
            busy_nxt = 1'b1;
         end
         SHOW: begin
            op_code_nxt = OP_DISP_R;
            disp_nxt    = result_nxt;
         end
         ERROR: begin
            err_nxt  = 1'b1;
            disp_nxt = 8'hEE;
         end
         default: begin
            op_code_nxt = OP_NOOP;
         end
      endcase
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed operand/op sequences against a small behavioural ALU.
// Expected SHOW/ERROR entries are queued at issue time and checked by an independent monitor.
// Timing, clear, ignore-next and reset-abandon behaviour are checked inline.

module tb_calc_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] sw;
   logic       next;
   logic       clear;
   logic [3:0] alu_a, alu_b;
   logic [2:0] op_code;
   logic [1:0] compute_op;
   logic [7:0] alu_result;
   logic       alu_done;
   logic       alu_div_by_zero;
   logic       alu_negative;
   logic [7:0] disp_value;
   logic [2:0] state_out;
   logic       busy, err, neg;

   // ALU model state
   logic [7:0] model_result;
   logic       model_done;
   logic       alu_hold;
   logic       late_done;

   assign alu_done   = model_done | late_done;
   assign alu_result = late_done ? 8'h55 : model_result;

   always #5 clk = ~clk;

   calc_sequencer #(.TIMEOUT(8)) dut (
      .clk             (clk),
      .reset           (reset),
      .sw              (sw),
      .next            (next),
      .clear           (clear),
      .alu_a           (alu_a),
      .alu_b           (alu_b),
      .op_code         (op_code),
      .compute_op      (compute_op),
      .alu_result      (alu_result),
      .alu_done        (alu_done),
      .alu_div_by_zero (alu_div_by_zero),
      .alu_negative    (alu_negative),
      .disp_value      (disp_value),
      .state_out       (state_out),
      .busy            (busy),
      .err             (err),
      .neg             (neg)
   );

   // Registered ALU: answers the cycle after op_code=101 unless held off.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         model_result    <= 8'h00;
         model_done      <= 1'b0;
         alu_div_by_zero <= 1'b0;
         alu_negative    <= 1'b0;
      end else begin
         model_done      <= 1'b0;
         alu_div_by_zero <= 1'b0;
         alu_negative    <= 1'b0;
         if (op_code == 3'b101 && !alu_hold) begin
            case (compute_op)
               2'b00: begin
                  model_result <= {4'h0, alu_a} + {4'h0, alu_b};
                  model_done   <= 1'b1;
               end
               2'b01: begin
                  model_result <= {4'h0, alu_a} - {4'h0, alu_b};
                  alu_negative <= (alu_a < alu_b);
                  model_done   <= 1'b1;
               end
               2'b10: begin
                  model_result <= {4'h0, alu_a} * {4'h0, alu_b};
                  model_done   <= 1'b1;
               end
               default: begin
                  if (alu_b == 4'h0) begin
                     alu_div_by_zero <= 1'b1;
                  end else begin
                     model_result <= {4'h0, alu_a} / {4'h0, alu_b};
                     model_done   <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   typedef struct packed {
      logic [2:0] st;
      logic [7:0] disp;
      logic       neg;
      logic       err;
      logic       busy;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [2:0] st, input logic [7:0] d, input logic n, input logic e);
      exp_t x;
      x.st   = st;
      x.disp = d;
      x.neg  = n;
      x.err  = e;
      x.busy = 1'b0;
      return x;
   endfunction

   // Monitor: every entry into SHOW or ERROR is a DUT "output event".
   logic [2:0] prev_st;
   always @(negedge clk) begin
      if (reset) begin
         prev_st = 3'd0;
      end else begin
         if (state_out != prev_st && (state_out == 3'd5 || state_out == 3'd6)) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: entered state %0d with nothing expected", state_out);
            end else begin
               mon_e = expq.pop_front();
               chk("out_state", state_out, mon_e.st);
               chk("out_disp", disp_value, mon_e.disp);
               chk("out_neg", neg, mon_e.neg);
               chk("out_err", err, mon_e.err);
               chk("out_busy", busy, mon_e.busy);
            end
         end
         prev_st = state_out;
      end
   end

   task automatic press(input logic [3:0] v);
      sw   = v;
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   // Ends at the negedge where the DUT sits in ISSUE.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      press(a);
      press(b);
      press({2'b00, op});
   endtask

   task automatic wait_state(input logic [2:0] s, input int limit, input string name, output int n);
      n = 0;
      while (state_out !== s && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk(name, state_out, s);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1; sw = 4'h0; next = 1'b0; clear = 1'b0;
      alu_hold = 1'b0; late_done = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_state", state_out, 3'd0);
      chk("rst_op", op_code, 3'b010);
      chk("rst_a", alu_a, 4'h0);
      chk("rst_b", alu_b, 4'h0);
      chk("rst_cop", compute_op, 2'b00);
      chk("rst_disp", disp_value, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_neg", neg, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      // ADD 3+4 = 7
      press(4'h3);
      chk("add_st_b", state_out, 3'd1);
      chk("add_a", alu_a, 4'h3);
      chk("add_op_b", op_code, 3'b100);
      chk("add_disp_b", disp_value, 8'h03);
      press(4'h4);
      chk("add_st_op", state_out, 3'd2);
      chk("add_b", alu_b, 4'h4);
      chk("add_op_noop", op_code, 3'b000);
      expq.push_back(mk(3'd5, 8'h07, 1'b0, 1'b0));
      press(4'h0);
      chk("add_st_issue", state_out, 3'd3);
      chk("add_op_comp", op_code, 3'b101);
      chk("add_busy_issue", busy, 1'b1);
      @(negedge clk);
      chk("add_st_wait", state_out, 3'd4);
      chk("add_op_wait", op_code, 3'b000);
      chk("add_busy_wait", busy, 1'b1);
      wait_state(3'd5, 4, "add_show", n);
      chk("add_op_show", op_code, 3'b110);
      pulse_clear();
      chk("add_clear_st", state_out, 3'd0);

      // SUB 2-5 = -3
      expq.push_back(mk(3'd5, 8'hFD, 1'b1, 1'b0));
      run_op(4'h2, 4'h5, 2'b01);
      wait_state(3'd5, 4, "sub_show", n);
      pulse_clear();
      chk("sub_clear_neg", neg, 1'b0);

      // MUL 3*4 = 0C, then next in SHOW
      expq.push_back(mk(3'd5, 8'h0C, 1'b0, 1'b0));
      run_op(4'h3, 4'h4, 2'b10);
      wait_state(3'd5, 4, "mul_show", n);
      press(4'h0);
`ifdef CALC_SEQ_CHAIN_EN
      chk("chain_st", state_out, 3'd1);
      chk("chain_a", alu_a, 4'hC);
`else
      chk("nochain_st", state_out, 3'd0);
      chk("nochain_a", alu_a, 4'h3);
`endif
      pulse_clear();

      // DIV 9/0 -> ERROR two cycles after ISSUE
      expq.push_back(mk(3'd6, 8'hEE, 1'b0, 1'b1));
      run_op(4'h9, 4'h0, 2'b11);
      wait_state(3'd6, 6, "div_err", n);
      chk("div_latency", n, 2);
      press(4'h1);
      chk("err_next_st", state_out, 3'd6);
      chk("err_next_err", err, 1'b1);
      chk("err_next_disp", disp_value, 8'hEE);
      pulse_clear();
      chk("err_clear_st", state_out, 3'd0);
      chk("err_clear_err", err, 1'b0);
      chk("err_clear_op", op_code, 3'b010);

      // Timeout: ALU silent, ERROR 8 cycles after entering WAIT_DONE
      alu_hold = 1'b1;
      expq.push_back(mk(3'd6, 8'hEE, 1'b0, 1'b1));
      run_op(4'h1, 4'h1, 2'b00);
      @(negedge clk);
      chk("to_st_wait", state_out, 3'd4);
      press(4'h5);
      chk("to_next_ignored", state_out, 3'd4);
      wait_state(3'd6, 20, "to_err", n);
      chk("to_latency", n + 1, 8);
      alu_hold = 1'b0;
      pulse_clear();

      // clear beats next in ENTER_B; alu_b keeps its old value
      press(4'h6);
      chk("cn_st_b", state_out, 3'd1);
      sw = 4'h9; next = 1'b1; clear = 1'b1;
      @(negedge clk);
      next = 1'b0; clear = 1'b0;
      chk("cn_st", state_out, 3'd0);
      chk("cn_b_kept", alu_b, 4'h1);
      chk("cn_a_kept", alu_a, 4'h6);

      // Reset during WAIT_DONE, then a late alu_done
      alu_hold = 1'b1;
      run_op(4'h2, 4'h3, 2'b00);
      @(negedge clk);
      chk("rw_st_wait", state_out, 3'd4);
      reset = 1'b1;
      #1;
      chk("rw_async_st", state_out, 3'd0);
      @(negedge clk);
      reset = 1'b0;
      late_done = 1'b1;
      repeat (2) @(negedge clk);
      late_done = 1'b0;
      @(negedge clk);
      chk("rw_st", state_out, 3'd0);
      chk("rw_op", op_code, 3'b010);
      chk("rw_busy", busy, 1'b0);
      chk("rw_err", err, 1'b0);
      chk("rw_a", alu_a, 4'h0);
      chk("rw_disp", disp_value, 8'h00);
      alu_hold = 1'b0;

      chk("queue_empty", expq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
